fifo_wptr_full: RTL and testbench

//  Write-domain pointer and full-flag generator for the async FIFO.

---
 rtl/async_fifo_pkg.sv | 13 +
 rtl/gray_counter.sv | 26 ++
 rtl/fifo_wptr_full.sv | 55 +++++
 tb/tb_fifo_wptr_full.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: Gray/binary conversion helpers shared by the write and read pointer blocks.
package async_fifo_pkg;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_counter.sv
// gray_counter: binary and Gray pointer register pair with increment enable.
module gray_counter
    import async_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);
    assign bin_next  = bin + W'(inc);
    assign gray_next = W'(bin2gray(32'(bin_next)));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full/almost-full flags, fill level and sticky overflow.
module fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);
    localparam int A     = ADDR_WIDTH;
    localparam int DEPTH = 1 << A;

    logic       wr_acc;
    logic [A:0] wbin, wbin_next, wgray_next, rbin, level_next;

    assign wr_acc = w_en & ~full;

    gray_counter #(.W(A + 1)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (wr_acc),
        .bin       (wbin),
        .gray      (wptr),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    assign waddr      = wbin[A-1:0];
    assign rbin       = (A + 1)'(gray2bin(32'(rptr_sync)));
    assign level_next = wbin_next - rbin;

    // Full when the next write pointer has lapped the reader by exactly one pass.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            full        <= wgray_next == {~rptr_sync[A:A-1], rptr_sync[A-2:0]};
            almost_full <= level_next >= (A + 1)'(DEPTH - AFULL_THRESH);
            wr_level    <= level_next;
            overflow    <= (w_en & full) | (overflow & ~ovf_clr);
        end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized write/read-pointer stimulus checked against a count-based FIFO model.
module tb_fifo_wptr_full;
    logic       clk = 0, rst_n = 1, w_en = 0, ovf_clr = 0, clk_on = 0;
    logic [4:0] rptr_sync = 0;
    logic [3:0] waddr;
    logic [4:0] wptr, wr_level;
    logic       full, almost_full, overflow;
    int         cmp = 0, err = 0;
    bit         chk_on = 0, skip_step = 0;

    always #5 if (clk_on) clk = ~clk;

    fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .rptr_sync   (rptr_sync),
        .ovf_clr     (ovf_clr),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    function automatic int g2b(input logic [4:0] g);
        for (int i = 0; i < 32; i++) if (5'(i ^ (i >> 1)) == g) return i;
        return 0;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: write count and fill level as plain integers modulo 32.
    int m_wbin, m_lvl;
    bit m_full, m_af, m_ovf;

    function automatic int nxt();
        return (m_wbin + ((w_en && !m_full) ? 1 : 0)) % 32;
    endfunction

    function automatic int lvl_of(input int wb);
        return (wb - g2b(rptr_sync) + 32) % 32;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_wbin <= 0;
            m_lvl  <= 0;
            m_full <= 0;
            m_af   <= 0;
            m_ovf  <= 0;
        end else begin
            m_wbin <= nxt();
            m_lvl  <= lvl_of(nxt());
            m_full <= lvl_of(nxt()) == 16;
            m_af   <= lvl_of(nxt()) >= 14;
            m_ovf  <= (w_en && m_full) || (m_ovf && !ovf_clr);
        end

    initial begin
        logic [4:0] prev;
        prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_on) begin
                check("wptr", wptr, b2g(m_wbin));
                check("waddr", waddr, m_wbin % 16);
                check("full", full, m_full);
                check("almost_full", almost_full, m_af);
                check("wr_level", wr_level, m_lvl);
                check("overflow", overflow, m_ovf);
                if (!skip_step) check("gray_step", $countones(wptr ^ prev) <= 1, 1);
            end
            skip_step = 0;
            prev = wptr;
        end
    end

    task automatic cyc(input logic we, input logic clr, input logic [4:0] rp);
        @(negedge clk);
        w_en = we;
        ovf_clr = clr;
        rptr_sync = rp;
    endtask

    task automatic zeros(input string tag);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_level"}, wr_level, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic pulse();
        @(posedge clk);
        #2;
        rst_n = 0;
        w_en = 0;
        ovf_clr = 0;
        rptr_sync = 0;
        skip_step = 1;
        #1;
        zeros("pulse");
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [4:0] q1, q2;
        int rd;
        bit saw0;
        #1 rst_n = 0;
        #1 zeros("rst");
        #1 rst_n = 1;
        chk_on = 1;
        clk_on = 1;

        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0);
            check("seq_waddr", waddr, i);
            if (i == 13) check("afull_13", almost_full, 0);
            if (i == 14) begin
                check("afull_14", almost_full, 1);
                check("level_14", wr_level, 14);
                check("model_lvl14", m_lvl, 14);
            end
        end
        cyc(1, 0, 0);
        check("full_16", full, 1);
        check("wptr_16", wptr, 5'b11000);
        check("level_16", wr_level, 16);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        check("ovf_set", overflow, 1);
        check("ovf_wptr", wptr, 5'b11000);
        check("ovf_waddr", waddr, 0);
        check("ovf_level", wr_level, 16);
        cyc(0, 0, 0);
        check("ovf_clr", overflow, 0);

        cyc(0, 0, 5'b00001);
        cyc(1, 0, 5'b00001);
        check("rd1_full", full, 0);
        check("rd1_level", wr_level, 15);
        check("rd1_afull", almost_full, 1);
        cyc(0, 0, 5'b00001);
        check("refull", full, 1);
        check("refull_level", wr_level, 16);

        q1 = wptr;
        q2 = wptr;
        saw0 = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, q2);
            q2 = q1;
            q1 = wptr;
            if (wptr == 0) saw0 = 1;
            if (i >= 1) check("track_not_full", full, 0);
        end
        check("track_wrapped", saw0, 1);

        rd = g2b(rptr_sync);
        for (int i = 0; i < 300; i++) begin
            if (((g2b(q2) - rd + 32) % 32) > 0 && $urandom_range(0, 1) == 1) rd = (rd + 1) % 32;
            cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0), b2g(rd));
            q2 = q1;
            q1 = wptr;
        end

        pulse();
        for (int i = 0; i < 7; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("level_7", wr_level, 7);
        pulse();
        cyc(1, 0, 0);
        check("post_rst_waddr", waddr, 0);
        cyc(0, 0, 0);
        check("post_rst_waddr1", waddr, 1);
        check("post_rst_wptr1", wptr, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
